// File: rtl/bidir_link_pkg.sv
// Shared FSM encodings, default parameters and counter sizing helper for the bidir link controller.
package bidir_link_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_TX_DEPTH  = 4;
  localparam int unsigned DEF_TURN_CYC  = 1;
  localparam int unsigned DEF_MAX_BURST = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TURN   = 2'd1;
  localparam logic [1:0] ST_DRIVE  = 2'd2;
  localparam logic [1:0] ST_LISTEN = 2'd3;

  // Bits needed to hold values 0..n
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bidir_link_fifo.sv
// Synchronous TX FIFO: registered storage, combinational head, wrap-bit pointers.
module bidir_link_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Exactly one word stored: a pop without push empties the FIFO
  assign last_o  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(1));

endmodule

// File: rtl/bidir_link_ctrl.sv
// Far-end controller for a shared tri-state bus: buffered TX bursts with turnaround, RX capture,
// contention flag. Define BIDIR_LINK_STATS_EN to add 16-bit tx/rx word counters.
module bidir_link_ctrl
  import bidir_link_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned TX_DEPTH  = DEF_TX_DEPTH,
  parameter int unsigned TURN_CYC  = DEF_TURN_CYC,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peer_oe_i,
  inout  wire  [WIDTH-1:0] bidir_io,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             link_oe_o,
  input  logic             clr_err_i,
  output logic             collision_o
`ifdef BIDIR_LINK_STATS_EN
  ,
  output logic [15:0]      tx_count_o,
  output logic [15:0]      rx_count_o
`endif
);

  localparam int unsigned TW = cnt_w(TURN_CYC);
  localparam int unsigned BW = cnt_w(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             coll_q, coll_d;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;

  logic             push, pop, rx_take;
  logic             fifo_full, fifo_empty, fifo_last;
  logic [WIDTH-1:0] fifo_head;

  bidir_link_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (tx_data_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  // Peer assertion drops our drive in the same cycle, so the bus never contends
  assign link_oe_o  = (state_q == ST_DRIVE) && !peer_oe_i;
  assign bidir_io   = link_oe_o ? fifo_head : {WIDTH{1'bz}};
  assign tx_ready_o = !fifo_full;
  assign push       = tx_valid_i && !fifo_full;
  assign pop        = link_oe_o;
  assign rx_take    = peer_oe_i && !link_oe_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
      coll_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      coll_q      <= coll_d;
      rx_valid_q  <= rx_take;
      if (rx_take) rx_data_q <= bidir_io;
    end
  end

  always_comb begin
    state_d     = state_q;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    coll_d      = clr_err_i ? 1'b0 : coll_q;
    case (state_q)
      ST_IDLE: begin
        if (peer_oe_i) state_d = ST_LISTEN;
        else if (!fifo_empty) begin
          state_d    = ST_TURN;
          turn_cnt_d = TW'(1);
        end
      end
      ST_TURN: begin
        if (peer_oe_i) state_d = ST_LISTEN;
        else if (32'(turn_cnt_q) == TURN_CYC) begin
          state_d     = ST_DRIVE;
          burst_cnt_d = '0;
        end else turn_cnt_d = turn_cnt_q + TW'(1);
      end
      ST_DRIVE: begin
        if (peer_oe_i) begin
          state_d = ST_LISTEN;
          coll_d  = 1'b1;
        end else begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          if ((fifo_last && !push) || (32'(burst_cnt_q) + 32'd1 == MAX_BURST)) state_d = ST_IDLE;
        end
      end
      ST_LISTEN: begin
        if (!peer_oe_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign collision_o = coll_q;

`ifdef BIDIR_LINK_STATS_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;

  // Counters wrap naturally at 0xFFFF; clr_err wins over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else if (clr_err_i) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (pop)     tx_cnt_q <= tx_cnt_q + 16'd1;
      if (rx_take) rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign tx_count_o = tx_cnt_q;
  assign rx_count_o = rx_cnt_q;
`endif

endmodule
